// File: rtl/sc_et_sng.sv
// Comparator-based stochastic number generator with early termination.
// Streams sc_bit = (x > cnt) aligned to the upstream counter wrap and reports ones count and length.
module sc_et_sng #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cnt,
    input  logic             ovf,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH:0]   in_et_len,
    output logic             sc_valid,
    output logic             sc_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_acc,
    output logic [WIDTH:0]   out_len
);

    // state | meaning
    // IDLE  | waiting for an operand, in_ready high
    // ALIGN | operand latched, waiting for upstream wrap so RUN starts at cnt = 0
    // RUN   | one live stream bit per cycle
    // DONE  | result held on out_acc/out_len until out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] x;
    logic [WIDTH:0]   et_len;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   len;

    logic             bit_now;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH:0]   len_next;
    logic             term;

    assign bit_now  = (x > cnt);
    assign sc_bit   = sc_valid & bit_now;
    assign in_ready = (state == IDLE);

    assign acc_next = acc + {{WIDTH{1'b0}}, bit_now};
    assign len_next = len + 1'b1;
    // The current bit always counts, so the length check uses the incremented value.
    assign term     = ovf || ((et_len != '0) && (len_next == et_len));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            et_len    <= '0;
            acc       <= '0;
            len       <= '0;
            sc_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x      <= in_x;
                        et_len <= in_et_len;
                        acc    <= '0;
                        len    <= '0;
                        state  <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (ovf) begin
                        sc_valid <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    len <= len_next;
                    if (term) begin
                        sc_valid  <= 1'b0;
                        out_valid <= 1'b1;
                        out_acc   <= acc_next;
                        out_len   <= len_next;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    sc_valid  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_et_sng.sv
// Randomized self-checking bench for sc_et_sng driven by a behavioural bypass counter.
// Expected stream bits, length and ones count are computed arithmetically per operation.
module tb_sc_et_sng;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cnt = 8'd0;
    logic       ovf;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [8:0] in_et_len;
    logic       sc_valid;
    logic       sc_bit;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_acc;
    logic [8:0] out_len;

    logic [7:0] bp = 8'd0;
    int checks = 0;
    int failures = 0;

    sc_et_sng #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cnt(cnt), .ovf(ovf),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_et_len(in_et_len),
        .sc_valid(sc_valid), .sc_bit(sc_bit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_len(out_len)
    );

    always #5 clk = ~clk;

    // Upstream counter: low bypassed bits read 0, the rest count; ovf marks the terminal value.
    assign ovf = ((cnt | bp) == 8'hFF);
    always @(posedge clk) cnt <= ((cnt | bp) + 8'd1) & ~bp;

    task automatic chk(input string tag, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("idle_ready", int'(in_ready), 1);
    endtask

    task automatic run_op(input int x, input int et, input int hold);
        int  step, p, elen, eacc, idx;
        bit  prev_sv, done;
        step = int'(bp) + 1;
        p    = 256 / step;
        elen = (et == 0 || et > p) ? p : et;
        eacc = 0;
        for (int i = 0; i < elen; i++) if (x > i * step) eacc++;

        wait_idle();
        in_valid  = 1'b1;
        in_x      = 8'(x);
        in_et_len = 9'(et);
        @(negedge clk);
        in_valid = 1'b0;
        chk("align_ready", int'(in_ready), 0);
        chk("align_sc_valid", int'(sc_valid), 0);

        idx = 0; prev_sv = 1'b0; done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            if (sc_valid) begin
                if (idx < elen) chk("sc_bit", int'(sc_bit), int'(x > idx * step));
                idx++;
            end
            if (out_valid) begin
                done = 1'b1;
                chk("out_latency", int'(prev_sv), 1);
                chk("done_sc_valid", int'(sc_valid), 0);
            end else begin
                prev_sv   = sc_valid;
                in_valid  = 1'($urandom_range(0, 1));
                in_x      = 8'($urandom);
                in_et_len = 9'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        chk("done_seen", int'(done), 1);
        chk("bits", idx, elen);
        chk("out_len", int'(out_len), elen);
        chk("out_acc", int'(out_acc), eacc);

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_x     = 8'($urandom);
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_len", int'(out_len), elen);
            chk("hold_acc", int'(out_acc), eacc);
            chk("hold_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", int'(out_valid), 0);
        chk("post_ready", int'(in_ready), 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_et_len = '0; out_ready = 1'b0;
        #1;
        chk("rst_sc_valid", int'(sc_valid), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_acc", int'(out_acc), 0);
        chk("rst_out_len", int'(out_len), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);

        // stray out_ready while idle must do nothing
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_out_valid", int'(out_valid), 0);

        bp = 8'd0;  run_op(128, 0, 0);
        bp = 8'd0;  run_op(64, 16, 0);
        bp = 8'd3;  run_op(100, 0, 0);
        bp = 8'd0;  run_op(0, 0, 0);
        bp = 8'd0;  run_op(255, 0, 0);
        bp = 8'd0;  run_op(77, 300, 0);
        bp = 8'd0;  run_op(200, 1, 5);
        bp = 8'd0;  run_op(10, 256, 0);

        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 4))
                0: bp = 8'd0;
                1: bp = 8'd1;
                2: bp = 8'd3;
                3: bp = 8'd7;
                default: bp = 8'd15;
            endcase
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 300)),
                   int'($urandom_range(0, 3)));
        end

        // reset mid-stream
        bp = 8'd0;
        wait_idle();
        in_valid = 1'b1; in_x = 8'd200; in_et_len = 9'd0;
        @(negedge clk);
        in_valid = 1'b0;
        begin
            int t = 0;
            while (!sc_valid && t < 600) begin
                @(negedge clk);
                t++;
            end
        end
        chk("pre_rst_running", int'(sc_valid), 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sc_valid", int'(sc_valid), 0);
        chk("mid_rst_sc_bit", int'(sc_bit), 0);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_acc", int'(out_acc), 0);
        chk("mid_rst_out_len", int'(out_len), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", int'(in_ready), 1);
        bp = 8'd1;  run_op(150, 40, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_et_sng.md
Name: sc_et_sng

Overview:
Comparator-based stochastic number generator with early termination. It sits directly downstream of the bypass counter and consumes that counter's `cnt`/`ovf` outputs.
- Takes a binary operand through a valid/ready handshake.
- Emits one SC bit per cycle: `sc_bit = (x > cnt)`.
- Accumulates the ones count and reports it with the stream length.
- A stream ends on counter wrap (`ovf`) or after a programmed length, whichever comes first.

Parameters:
- WIDTH, 8, operand/counter width. Must match the upstream counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cnt  input  WIDTH  upstream counter value. Bypassed bits read 0.
- ovf  input  1  upstream wrap flag. High for exactly the cycle cnt holds its terminal value; cnt is 0 the next cycle.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept an operand.
- in_x  input  WIDTH  operand, unsigned.
- in_et_len  input  WIDTH+1  early-termination length; 0 = full period.
- sc_valid  output  1  sc_bit is a live stream bit this cycle.
- sc_bit  output  1  stochastic bit.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  WIDTH+1  ones count of the stream.
- out_len  output  WIDTH+1  number of stream bits.

Behaviour:
- Reset (async, immediate, valid mid-stream):
  - state = IDLE.
  - x, et_len, acc, len = 0.
  - sc_valid, sc_bit, out_valid = 0; out_acc, out_len = 0.
  - in_ready = 1 while rst_n is high in IDLE.
- FSM states: IDLE, ALIGN, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch in_x → x and in_et_len → et_len; clear acc and len; go to ALIGN.
- ALIGN:
  - in_ready = 0, sc_valid = 0.
  - Waits for ovf = 1, then goes to RUN, so the first RUN cycle sees cnt = 0.
  - If ovf is high on the cycle after acceptance, RUN starts the following cycle. There is no skip; alignment is always to the next observed ovf.
- RUN:
  - sc_valid = 1, sc_bit = (x > cnt), combinational on cnt.
  - Each cycle: acc += sc_bit, len += 1.
  - Terminate at the end of the cycle if ovf = 1, or if et_len != 0 and len + 1 == et_len. The current bit is included. Go to DONE.
  - Both terminate conditions in the same cycle are a single termination.
- DONE:
  - out_valid = 1; out_acc = acc, out_len = len, stable until the handshake.
  - sc_valid = 0, in_ready = 0.
  - On out_ready, go to IDLE next cycle.
  - A new operand is accepted no earlier than the cycle after the result handshake.
- Width rules:
  - acc and len are WIDTH+1 bits, maximum 2^WIDTH; no saturation needed.
  - Comparison is unsigned WIDTH-bit.
- Boundary conditions:
  - et_len > period: ovf terminates first and out_len = period.
  - et_len = 1: one bit.
  - x = 0: acc = 0.
  - in_valid asserted while not IDLE is ignored and the operand is not latched.
  - out_ready asserted outside DONE has no effect.
- Latency:
  - Acceptance to first sc bit is ≥ 2 cycles (ALIGN wait).
  - Last sc bit to out_valid is 1 cycle.

Test Plan:
- WIDTH=8, bp=0, x=128, et_len=0 → 256 sc bits, out_len=256, out_acc=128.
- bp=0, x=64, et_len=16 → out_len=16, out_acc=16 (cnt 0..15 all < 64); out_valid exactly 1 cycle after the 16th bit.
- Upstream bp=8'b00000011 (cnt = 0,4,…,252), x=100, et_len=0 → out_len=64, out_acc=25.
- x=0 → out_acc=0. x=255, bp=0 → out_acc=255, out_len=256. et_len=300 → out_len=256.
- Hold out_ready low 5 cycles in DONE → out_valid, out_acc, out_len stable, in_ready=0, in_valid ignored. Release → IDLE next cycle, then a new operand is accepted.
- Assert rst_n=0 mid-RUN → outputs zero immediately, sc_valid=0. After release: in_ready=1, and the next operation completes correctly.
